// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M/W shadow scoreboard driving stalls, flushes, forwarding selects and perf counters
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_flush,
  output logic [CNT_W-1:0]  cnt_retire
);

  logic              eV, eRw, eLd, eU1, eU2;
  logic [REG_AW-1:0] eRd, eRs1, eRs2;
  logic              mV, mRw, mLd;
  logic [REG_AW-1:0] mRd;
  logic              wV, wRw;
  logic [REG_AW-1:0] wRd;
  logic              rawStall;

  function automatic logic writes(input logic v, input logic rw,
                                  input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] r);
    return v & rw & (rd == r) & (r != '0);
  endfunction

  // With forwarding only a load in E cannot be bypassed; without it every in-flight writer blocks.
  always_comb begin
    rawStall = 1'b0;
    if (FWD_EN) begin
      rawStall = id_valid & eLd &
                 ((id_rs1_used & writes(eV, eRw, eRd, id_rs1)) |
                  (id_rs2_used & writes(eV, eRw, eRd, id_rs2)));
    end else begin
      rawStall = id_valid &
                 ((id_rs1_used & (writes(eV, eRw, eRd, id_rs1) | writes(mV, mRw, mRd, id_rs1) |
                                  writes(wV, wRw, wRd, id_rs1))) |
                  (id_rs2_used & (writes(eV, eRw, eRd, id_rs2) | writes(mV, mRw, mRd, id_rs2) |
                                  writes(wV, wRw, wRd, id_rs2))));
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (mem_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (ex_redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (rawStall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    fwd_a_d = 1'b0;
    fwd_b_d = 1'b0;
    if (FWD_EN && !rst) begin
      if (eU1 && writes(mV, mRw, mRd, eRs1))      fwd_a_e = 2'b10;
      else if (eU1 && writes(wV, wRw, wRd, eRs1)) fwd_a_e = 2'b01;
      if (eU2 && writes(mV, mRw, mRd, eRs2))      fwd_b_e = 2'b10;
      else if (eU2 && writes(wV, wRw, wRd, eRs2)) fwd_b_e = 2'b01;
      fwd_a_d = id_valid & id_rs1_used & writes(wV, wRw, wRd, id_rs1);
      fwd_b_d = id_valid & id_rs2_used & writes(wV, wRw, wRd, id_rs2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eV <= 1'b0; eRw <= 1'b0; eLd <= 1'b0; eU1 <= 1'b0; eU2 <= 1'b0;
      eRd <= '0; eRs1 <= '0; eRs2 <= '0;
      mV <= 1'b0; mRw <= 1'b0; mLd <= 1'b0; mRd <= '0;
      wV <= 1'b0; wRw <= 1'b0; wRd <= '0;
      cnt_stall  <= '0;
      cnt_flush  <= '0;
      cnt_retire <= '0;
    end else if (mem_busy) begin
      if (cnt_stall != '1) cnt_stall <= cnt_stall + CNT_W'(1);
    end else begin
      wV <= mV; wRw <= mRw; wRd <= mRd;
      mV <= eV; mRw <= eRw; mRd <= eRd; mLd <= eLd;
      // Bubbles carry no source-used bits so they never request a forward.
      if (ex_redirect || rawStall) begin
        eV <= 1'b0; eRw <= 1'b0; eLd <= 1'b0; eU1 <= 1'b0; eU2 <= 1'b0;
        eRd <= '0; eRs1 <= '0; eRs2 <= '0;
      end else begin
        eV <= id_valid; eRw <= id_regwrite; eLd <= id_is_load;
        eU1 <= id_rs1_used; eU2 <= id_rs2_used;
        eRd <= id_rd; eRs1 <= id_rs1; eRs2 <= id_rs2;
      end
      if (ex_redirect) begin
        if (cnt_flush != '1) cnt_flush <= cnt_flush + CNT_W'(1);
      end else if (rawStall) begin
        if (cnt_stall != '1) cnt_stall <= cnt_stall + CNT_W'(1);
      end
      if (wV && cnt_retire != '1) cnt_retire <= cnt_retire + CNT_W'(1);
    end
  end

  // A load still in M must never be a forwarding source; the load-use stall keeps it out of reach.
  always_ff @(posedge clk) begin
    if (!rst && FWD_EN && eV && mLd)
      assert (!((eU1 && writes(mV, mRw, mRd, eRs1)) || (eU2 && writes(mV, mRw, mRd, eRs2))));
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard-queue bench for hazard_scoreboard (forwarding, no-forward and 4-bit counter builds)
module tb_hazard_scoreboard;
  localparam int AW = 5;
  // ctl bits: stall_f stall_d stall_e stall_m flush_d flush_e fwd_a_e[2] fwd_b_e[2] fwd_a_d fwd_b_d
  localparam logic [11:0] NONE = 12'h000, RSTC = 12'h0C0, RDR = 12'h0C0, FRZ = 12'hF00, RAW = 12'hC40;
  localparam logic [11:0] AE10 = 12'h020, AE01 = 12'h010, BE10 = 12'h008, BE01 = 12'h004;
  localparam logic [11:0] AD = 12'h002, BD = 12'h001;

  typedef struct packed {
    logic busy; logic redir; logic v;
    logic [AW-1:0] rs1; logic u1; logic [AW-1:0] rs2; logic u2;
    logic [AW-1:0] rd; logic rw; logic ld;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_is_load, ex_redirect, mem_busy;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  wire [11:0] ctlF, ctlN, ctlS;
  wire [31:0] stallF, flushF, retireF, stallN, flushN, retireN;
  wire [3:0]  stallS, flushS, retireS;

  int total = 0;
  int bad = 0;
  logic [11:0] expQ[$];

  hazard_scoreboard #(.REG_AW(AW), .FWD_EN(1'b1), .CNT_W(32)) dutF (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall_f(ctlF[11]), .stall_d(ctlF[10]), .stall_e(ctlF[9]), .stall_m(ctlF[8]),
    .flush_d(ctlF[7]), .flush_e(ctlF[6]), .fwd_a_e(ctlF[5:4]), .fwd_b_e(ctlF[3:2]),
    .fwd_a_d(ctlF[1]), .fwd_b_d(ctlF[0]),
    .cnt_stall(stallF), .cnt_flush(flushF), .cnt_retire(retireF));

  hazard_scoreboard #(.REG_AW(AW), .FWD_EN(1'b0), .CNT_W(32)) dutN (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall_f(ctlN[11]), .stall_d(ctlN[10]), .stall_e(ctlN[9]), .stall_m(ctlN[8]),
    .flush_d(ctlN[7]), .flush_e(ctlN[6]), .fwd_a_e(ctlN[5:4]), .fwd_b_e(ctlN[3:2]),
    .fwd_a_d(ctlN[1]), .fwd_b_d(ctlN[0]),
    .cnt_stall(stallN), .cnt_flush(flushN), .cnt_retire(retireN));

  hazard_scoreboard #(.REG_AW(AW), .FWD_EN(1'b1), .CNT_W(4)) dutS (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall_f(ctlS[11]), .stall_d(ctlS[10]), .stall_e(ctlS[9]), .stall_m(ctlS[8]),
    .flush_d(ctlS[7]), .flush_e(ctlS[6]), .fwd_a_e(ctlS[5:4]), .fwd_b_e(ctlS[3:2]),
    .fwd_a_d(ctlS[1]), .fwd_b_d(ctlS[0]),
    .cnt_stall(stallS), .cnt_flush(flushS), .cnt_retire(retireS));

  function automatic stim_t mk(input logic v, input int rs1, input logic u1, input int rs2, input logic u2,
                               input int rd, input logic rw, input logic ld,
                               input logic redir = 1'b0, input logic busy = 1'b0);
    stim_t s;
    s.busy = busy; s.redir = redir; s.v = v;
    s.rs1 = AW'(rs1); s.u1 = u1; s.rs2 = AW'(rs2); s.u2 = u2;
    s.rd = AW'(rd); s.rw = rw; s.ld = ld;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    mem_busy = s.busy; ex_redirect = s.redir; id_valid = s.v;
    id_rs1 = s.rs1; id_rs1_used = s.u1; id_rs2 = s.rs2; id_rs2_used = s.u2;
    id_rd = s.rd; id_regwrite = s.rw; id_is_load = s.ld;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset;
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [11:0] want;
    rst = 1'b1;
    apply(mk(1, 5, 1, 6, 1, 7, 1, 1, 1'b1, 1'b1));
    tick;
    expQ.push_back(RSTC);
    #2;
    want = expQ.pop_front();
    total++;
    if (ctlF !== want) begin bad++; $display("FAIL reset ctlF got=%h want=%h", ctlF, want); end
    total++;
    if (ctlN !== want) begin bad++; $display("FAIL reset ctlN got=%h want=%h", ctlN, want); end
    total++;
    if (ctlS !== want) begin bad++; $display("FAIL reset ctlS got=%h want=%h", ctlS, want); end
    total++;
    if ({stallF, flushF, retireF} !== 96'd0) begin
      bad++; $display("FAIL reset counters got=%h/%h/%h want=0", stallF, flushF, retireF);
    end
    rst = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tick;
  endtask

  task automatic test_forwarding;
    stim_t s[$];
    logic [11:0] e[$];
    logic [11:0] want;
    applyReset;
    s.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0)); e.push_back(NONE);
    s.push_back(mk(1, 5, 1, 2, 1, 5, 1, 0)); e.push_back(NONE);
    s.push_back(mk(1, 3, 1, 5, 1, 7, 1, 0)); e.push_back(AE10);
    s.push_back(mk(1, 1, 1, 5, 1, 0, 1, 0)); e.push_back(BE10 | BD);
    s.push_back(mk(1, 0, 1, 7, 1, 8, 1, 0)); e.push_back(BE01);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(BE01);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(NONE);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      expQ.push_back(e[i]);
      #2;
      want = expQ.pop_front();
      total++;
      if (ctlF !== want) begin bad++; $display("FAIL fwd[%0d] ctl got=%h want=%h", i, ctlF, want); end
      tick;
    end
  endtask

  task automatic test_load_use;
    stim_t s[$];
    logic [11:0] e[$];
    logic [11:0] want;
    applyReset;
    s.push_back(mk(1, 1, 1, 0, 0, 7, 1, 1)); e.push_back(NONE);
    s.push_back(mk(1, 2, 1, 7, 1, 9, 1, 0)); e.push_back(RAW);
    s.push_back(mk(1, 2, 1, 7, 1, 9, 1, 0)); e.push_back(NONE);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(BE01);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      expQ.push_back(e[i]);
      #2;
      want = expQ.pop_front();
      total++;
      if (ctlF !== want) begin bad++; $display("FAIL loaduse[%0d] ctl got=%h want=%h", i, ctlF, want); end
      tick;
    end
    total++;
    if (stallF !== 32'd1) begin bad++; $display("FAIL loaduse cnt_stall got=%0d want=1", stallF); end
  endtask

  task automatic test_redirect;
    stim_t s[$];
    logic [11:0] e[$];
    logic [11:0] want;
    applyReset;
    s.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0));       e.push_back(NONE);
    s.push_back(mk(1, 3, 1, 4, 1, 2, 1, 0, 1'b1)); e.push_back(RDR);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));       e.push_back(NONE);
    s.push_back(mk(1, 1, 1, 0, 0, 8, 1, 0));       e.push_back(AD);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));       e.push_back(NONE);
    s.push_back(mk(1, 3, 1, 4, 1, 2, 1, 0, 1'b1)); e.push_back(RDR);
    s.push_back(mk(1, 3, 1, 4, 1, 2, 1, 0, 1'b1)); e.push_back(RDR);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));       e.push_back(NONE);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      expQ.push_back(e[i]);
      #2;
      want = expQ.pop_front();
      total++;
      if (ctlF !== want) begin bad++; $display("FAIL redirect[%0d] ctl got=%h want=%h", i, ctlF, want); end
      if (i == 3) begin
        total++;
        if (flushF !== 32'd1 || retireF !== 32'd0) begin
          bad++; $display("FAIL redirect mid counters got=%0d/%0d want=1/0", flushF, retireF);
        end
      end
      tick;
    end
    total++;
    if (flushF !== 32'd3) begin bad++; $display("FAIL redirect cnt_flush got=%0d want=3", flushF); end
    total++;
    if (retireF !== 32'd2) begin bad++; $display("FAIL redirect cnt_retire got=%0d want=2", retireF); end
  endtask

  task automatic test_no_forward;
    stim_t s[$];
    logic [11:0] e[$];
    logic [11:0] want;
    applyReset;
    s.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0)); e.push_back(NONE);
    s.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0)); e.push_back(RAW);
    s.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0)); e.push_back(RAW);
    s.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0)); e.push_back(RAW);
    s.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0)); e.push_back(NONE);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(NONE);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      expQ.push_back(e[i]);
      #2;
      want = expQ.pop_front();
      total++;
      if (ctlN !== want) begin bad++; $display("FAIL nofwd[%0d] ctl got=%h want=%h", i, ctlN, want); end
      tick;
    end
    total++;
    if (stallN !== 32'd3) begin bad++; $display("FAIL nofwd cnt_stall got=%0d want=3", stallN); end
  endtask

  task automatic test_mem_busy;
    stim_t s[$];
    logic [11:0] e[$];
    logic [11:0] want;
    applyReset;
    s.push_back(mk(1, 1, 1, 0, 0, 7, 1, 1)); e.push_back(NONE);
    for (int k = 0; k < 4; k++) begin
      s.push_back(mk(1, 7, 1, 0, 0, 9, 1, 0, 1'b0, 1'b1)); e.push_back(FRZ);
    end
    s.push_back(mk(1, 7, 1, 0, 0, 9, 1, 0)); e.push_back(RAW);
    s.push_back(mk(1, 7, 1, 0, 0, 9, 1, 0)); e.push_back(NONE);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(AE01);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1)); e.push_back(FRZ);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b1)); e.push_back(RDR);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(NONE);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      expQ.push_back(e[i]);
      #2;
      want = expQ.pop_front();
      total++;
      if (ctlF !== want) begin bad++; $display("FAIL busy[%0d] ctl got=%h want=%h", i, ctlF, want); end
      if (i == 7) begin
        total++;
        if (stallF !== 32'd5) begin bad++; $display("FAIL busy cnt_stall got=%0d want=5", stallF); end
      end
      tick;
    end
    total++;
    if (stallF !== 32'd6 || flushF !== 32'd1) begin
      bad++; $display("FAIL busy end counters got=%0d/%0d want=6/1", stallF, flushF);
    end
  endtask

  task automatic test_reset_saturation;
    logic [11:0] want;
    applyReset;
    apply(mk(1, 0, 0, 0, 0, 10, 1, 0));
    for (int k = 0; k < 25; k++) tick;
    total++;
    if (retireS !== 4'd15) begin bad++; $display("FAIL sat cnt_retire4 got=%0d want=15", retireS); end
    total++;
    if (retireF !== 32'd22) begin bad++; $display("FAIL sat cnt_retire32 got=%0d want=22", retireF); end
    apply(mk(1, 0, 0, 0, 0, 10, 1, 0, 1'b0, 1'b1));
    expQ.push_back(FRZ);
    #2;
    want = expQ.pop_front();
    total++;
    if (ctlS !== want) begin bad++; $display("FAIL sat freeze ctl got=%h want=%h", ctlS, want); end
    tick;
    rst = 1'b1;
    expQ.push_back(RSTC);
    #2;
    want = expQ.pop_front();
    total++;
    if (ctlS !== want) begin bad++; $display("FAIL rst-in-freeze ctl got=%h want=%h", ctlS, want); end
    tick;
    rst = 1'b0;
    apply(mk(1, 10, 1, 0, 0, 11, 1, 0));
    expQ.push_back(NONE);
    #2;
    want = expQ.pop_front();
    total++;
    if (ctlS !== want) begin bad++; $display("FAIL post-reset ctl got=%h want=%h", ctlS, want); end
    total++;
    if ({stallS, flushS, retireS} !== 12'd0 || retireF !== 32'd0 || stallF !== 32'd0) begin
      bad++; $display("FAIL post-reset counters got=%0d/%0d/%0d/%0d want=0", stallS, retireS, retireF, stallF);
    end
    for (int k = 0; k < 3; k++) tick;
    total++;
    if (retireF !== 32'd0) begin bad++; $display("FAIL post-reset stale retire got=%0d want=0", retireF); end
    tick;
    total++;
    if (retireF !== 32'd1) begin bad++; $display("FAIL post-reset first retire got=%0d want=1", retireF); end
  endtask

  initial begin
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    test_reset;
    test_forwarding;
    test_load_use;
    test_redirect;
    test_no_forward;
    test_mem_busy;
    test_reset_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the 5-stage RV32I pipeline, replacing the purely combinational forwarding unit. It keeps its own shadow scoreboard of the instructions in E/M/W (valid, rd, regwrite, load, rs1/rs2). From that scoreboard and the decode-stage fields it generates forwarding selects, load-use stalls, redirect flushes and whole-pipe freezes on a busy memory. It adds selectable no-forward mode and saturating performance counters, which the current unit lacks.

## Interface
Parameters:
- REG_AW, 5, register address width (2^REG_AW architectural registers; register 0 hard-wired zero)
- FWD_EN, 1, 1 = forwarding on; 0 = no forwarding, resolve every RAW by stalling
- CNT_W, 32, width of each performance counter

Ports (clock and reset first):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  D holds a real instruction
- id_rs1, id_rs2  in  REG_AW  D source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  REG_AW  D destination
- id_regwrite, id_is_load  in  1  D writes rd / D is a load
- ex_redirect  in  1  taken branch, jal or jalr resolved in E this cycle
- mem_busy  in  1  data memory not ready; freeze pipe
- stall_f, stall_d, stall_e, stall_m  out  1  hold the F/D/E/M pipeline registers
- flush_d, flush_e  out  1  load a bubble into the D/E pipeline registers
- fwd_a_e, fwd_b_e  out  2  E operand select: 00 regfile, 01 ResultW, 10 ALU_ResultM
- fwd_a_d, fwd_b_d  out  1  D operand takes ResultW (regfile not write-through)
- cnt_stall, cnt_flush, cnt_retire  out  CNT_W  performance counters

## Operation
- Scoreboard: E, M and W slots. Each slot holds v, rd, rw and ld; the E slot also holds rs1, rs2, u1 and u2. A slot "writes r" when v & rw & rd==r & r!=0.
- Per-cycle priority: rst > mem_busy > ex_redirect > RAW stall > normal.
- mem_busy:
  - stall_f/d/e/m = 1; flushes = 0; scoreboard holds.
  - fwd selects are still driven from the held scoreboard.
- ex_redirect (no mem_busy):
  - flush_d = flush_e = 1; stalls = 0; RAW stall ignored.
  - Next cycle: E slot = bubble, M = old E (so jal/jalr rd still retires), W = old M.
- RAW stall, FWD_EN=1: E slot is a load and id_rs1 or id_rs2 (with its used bit) is written by it.
- RAW stall, FWD_EN=0: any used id_rs is written by the E, M or W slot.
- RAW stall response:
  - stall_f = stall_d = 1, flush_e = 1.
  - Next cycle: E = bubble, M = old E, W = old M.
- Normal: W ← M, M ← E, E ← D fields with v = id_valid.
- fwd_x_e (FWD_EN=1): 10 if the M slot writes E.rsx & E.ux; else 01 if the W slot writes E.rsx & E.ux; else 00. The M slot wins over W.
- An M-slot load never matches after a correct stall. This is checked by assertion; fwd does not special-case it.
- fwd_x_d = FWD_EN & id_valid & (W slot writes id_rsx) & id_rsx_used.
- With FWD_EN=0, every fwd output is constant 0.
- Counters (saturate at all-ones, never wrap):
  - cnt_stall +1 on each RAW-stall or mem_busy cycle.
  - cnt_flush +1 on each ex_redirect cycle that is not under mem_busy.
  - cnt_retire +1 on each cycle with W slot v=1 and no mem_busy.

## Timing
- Stall, flush and fwd outputs are combinational from the registered scoreboard plus the current D inputs, mem_busy and ex_redirect. Zero-cycle latency; no internal pipelining of these decisions.
- Scoreboard and counters update on the rising clk edge.
- Load-use penalty: exactly 1 bubble with FWD_EN=1.
- No-forward penalty: up to 3 bubbles, until the writer has left W.
- Redirect penalty: 2 bubbles (D and E).
- Reset (rst=1 at an edge):
  - All slot v = 0; counters = 0.
  - While rst is high: flush_d = flush_e = 1, all stalls 0, all fwd 0.
- Reset asserted mid-stall or mid-freeze discards all scoreboard contents on that edge.
- Back-to-back redirects each flush independently, with no stall interaction.
- ex_redirect together with mem_busy: the freeze wins; the redirect must still be presented once the freeze ends.

## Test plan
- Forwarding, FWD_EN=1: add x5 in E, then M; dependent add x6,x5 reaches E with add x5 in M → fwd_a_e=10. One instruction later (writer in W) → 01. Writer with rd=x0 → 00, never forwarded.
- Load-use: lw x7 in E, D uses x7 as rs2 → stall_f=stall_d=flush_e=1 for exactly 1 cycle. Next cycle the user is in E, lw is in W → fwd_b_e=01, cnt_stall=1.
- Redirect: ex_redirect=1 for 1 cycle → flush_d=flush_e=1. Two cycles later the W slot holds the jal (rd=x1), cnt_flush=1, cnt_retire counts the jal.
- FWD_EN=0 build: add x5 followed by a user of x5 → 3 consecutive stall cycles. fwd outputs stay 0 throughout; cnt_stall=3.
- mem_busy held 4 cycles during a load-use condition:
  - All stalls=1 and flushes=0 for all 4 cycles; scoreboard unchanged.
  - Load-use bubble inserted on the first free cycle.
  - cnt_stall = 5.
- Reset mid-freeze plus saturation:
  - rst during mem_busy → next cycle all v=0, counters 0.
  - With CNT_W=4, run 20 retiring cycles → cnt_retire=15.
